// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path. This package holds
// the opcodes, the FSM state encodings, the ALU codes and the datapath select
// encodings, plus the per-state Moore output table.
package cpu_ctrl_pkg;

  localparam int OPW    = 4;
  localparam int STATEW = 4;

  // Opcodes (instr[15:12]); 0000-0011 are R-type, 1010-1111 are illegal
  localparam logic [OPW-1:0] OP_ADDI = 4'b0100;
  localparam logic [OPW-1:0] OP_LW   = 4'b0101;
  localparam logic [OPW-1:0] OP_SW   = 4'b0110;
  localparam logic [OPW-1:0] OP_BEQ  = 4'b0111;
  localparam logic [OPW-1:0] OP_BGT  = 4'b1000;
  localparam logic [OPW-1:0] OP_J    = 4'b1001;

  // ALUControl codes, shared with the ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Datapath select encodings
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_REGA     = 2'b10;
  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_ONE      = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef enum logic [STATEW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
  } ctrl_t;

  // Moore outputs for each state; anything not listed stays 0
  function automatic ctrl_t moore_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_ONE;
        c.result_src = RES_ALURESULT;
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_REGA;
        c.alu_src_b = SRCB_REGB;
      end
      S_EXECI, S_MEMADR: begin
        c.alu_src_a = SRCA_REGA;
        c.alu_src_b = SRCB_IMM;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMRD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_MEMDATA;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_REGA;
        c.alu_src_b  = SRCB_REGB;
        c.result_src = RES_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.result_src = RES_ALUOUT;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: picks the ALUControl code from the current FSM state
// and, for R-type execution, the low opcode bits.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  output logic [1:0]     alu_control
);

  // Address/target arithmetic adds, branches compare by subtracting
  always_comb begin
    alu_control = ALU_ADD;
    case (state)
      S_EXECR:  alu_control = opcode[1:0];
      S_BRANCH: alu_control = ALU_SUB;
      default:  alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit RISC CPU. Moore outputs are held in a
// register loaded with the table entry of the state being entered; the branch
// PC write and the illegal-opcode done pulse are resolved combinationally.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int STATEW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero_flag,
  input  logic              greater_flag,
  output logic [1:0]        ALUControl,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic              AdrSrc,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              instr_done,
  output logic [STATEW-1:0] state
);

  state_t state_q;
  state_t next_state;
  ctrl_t  ctrl_q;
  logic   is_rtype;
  logic   is_illegal;
  logic   legal_state;
  logic   branch_taken;
  logic   en_ok;

  assign is_rtype    = (opcode[3:2] == 2'b00);
  assign is_illegal  = (opcode > OP_J);
  assign legal_state = (state_q <= S_JUMP);
  // Writes are suppressed while reset is held or the state register is corrupt
  assign en_ok       = ~reset & legal_state;

  // Strict greater-than for BGT: non-negative and non-zero difference
  assign branch_taken = (opcode == OP_BEQ) ? zero_flag : (greater_flag & ~zero_flag);

  // Next-state selection; unknown encodings fall back to FETCH
  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (is_rtype) next_state = S_EXECR;
        else begin
          case (opcode)
            OP_ADDI:      next_state = S_EXECI;
            OP_LW, OP_SW: next_state = S_MEMADR;
            OP_BEQ, OP_BGT: next_state = S_BRANCH;
            OP_J:         next_state = S_JUMP;
            default:      next_state = S_FETCH;
          endcase
        end
      end
      S_EXECR, S_EXECI: next_state = S_ALUWB;
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // State and registered Moore outputs; reset parks both on FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= next_state;
      ctrl_q  <= moore_ctrl(next_state);
    end
  end

  alu_decoder u_alu_decoder (
    .state       (state_q),
    .opcode      (opcode),
    .alu_control (ALUControl)
  );

  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign AdrSrc     = ctrl_q.adr_src;
  assign IRWrite    = ctrl_q.ir_write & en_ok;
  assign PCWrite    = (ctrl_q.pc_write | ((state_q == S_BRANCH) & branch_taken)) & en_ok;
  assign RegWrite   = ctrl_q.reg_write & en_ok;
  assign MemWrite   = ctrl_q.mem_write & en_ok;
  assign instr_done = (ctrl_q.instr_done | ((state_q == S_DECODE) & is_illegal)) & en_ok;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed and randomized instruction
// streams compared cycle by cycle against a per-instruction reference model.
module tb_multicycle_control;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero_flag, greater_flag;
  logic [1:0] ALUControl, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.OPW(4), .STATEW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .zero_flag    (zero_flag),
    .greater_flag (greater_flag),
    .ALUControl   (ALUControl),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ResultSrc    (ResultSrc),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .instr_done   (instr_done),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Observed control word: {ALUControl, A, B, ResultSrc, AdrSrc, IRWrite,
  // PCWrite, RegWrite, MemWrite, instr_done}
  function automatic logic [13:0] obs_word();
    return {ALUControl, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite,
            PCWrite, RegWrite, MemWrite, instr_done};
  endfunction

  // Number of cycles from FETCH back to FETCH for an opcode
  function automatic int instr_len(logic [3:0] op);
    if (op >= 4'd10) return 2;
    if (op == 4'd5) return 5;
    if (op >= 4'd7) return 3;
    return 4;
  endfunction

  // Reference: control word expected in cycle k of an instruction
  function automatic logic [13:0] exp_word(logic [3:0] op, int k, logic z, logic g);
    logic [1:0] alu, a, b, res;
    logic adr, irw, pcw, rw, mw, done;
    alu = 2'b00; a = 2'b00; b = 2'b00; res = 2'b00;
    adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; done = 1'b0;
    if (k == 0) begin
      b = 2'b10; res = 2'b10; irw = 1'b1; pcw = 1'b1;
    end else if (k == 1) begin
      a = 2'b01; b = 2'b01; done = (op >= 4'd10);
    end else if (op <= 4'd3) begin
      if (k == 2) begin a = 2'b10; alu = op[1:0]; end
      else begin rw = 1'b1; done = 1'b1; end
    end else begin
      case (op)
        4'd4: if (k == 2) begin a = 2'b10; b = 2'b01; end
              else begin rw = 1'b1; done = 1'b1; end
        4'd5: if (k == 2) begin a = 2'b10; b = 2'b01; end
              else if (k == 3) adr = 1'b1;
              else begin res = 2'b01; rw = 1'b1; done = 1'b1; end
        4'd6: if (k == 2) begin a = 2'b10; b = 2'b01; end
              else begin adr = 1'b1; mw = 1'b1; done = 1'b1; end
        4'd7, 4'd8: begin
          a = 2'b10; alu = 2'b01; done = 1'b1;
          pcw = (op == 4'd7) ? z : (g & ~z);
        end
        default: begin pcw = 1'b1; done = 1'b1; end
      endcase
    end
    return {alu, a, b, res, adr, irw, pcw, rw, mw, done};
  endfunction

  // Runs the first ncyc cycles of one instruction (ncyc=0: all of them),
  // starting with the DUT in FETCH just after a rising edge
  task automatic run_instr(input logic [3:0] op, input logic z, input logic g,
                           input int ncyc, input string tag);
    int n;
    logic [13:0] exp, got;
    n = (ncyc == 0) ? instr_len(op) : ncyc;
    for (int k = 0; k < n; k++) begin
      opcode = (k == 0) ? 4'($urandom) : op;
      if (k == 2 && (op == 4'd7 || op == 4'd8)) begin
        zero_flag = z; greater_flag = g;
      end else begin
        zero_flag = 1'($urandom); greater_flag = 1'($urandom);
      end
      @(negedge clk);
      exp = exp_word(op, k, z, g);
      got = obs_word();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s op=%b cycle=%0d: got %b expected %b", tag, op, k, got, exp);
      end
      checks++;
      if (RegWrite === 1'b1 && MemWrite === 1'b1) begin
        errors++;
        $display("FAIL %s_exclusive op=%b cycle=%0d: got RegWrite=1 MemWrite=1 expected at most one", tag, op, k);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 4'b0101; zero_flag = 1'b0; greater_flag = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_word() !== 14'b00_00_10_10_0_0_0_0_0_0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs_word(), 14'b00_00_10_10_0_0_0_0_0_0);
    end
    checks++;
    if (state !== S_FETCH) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state, S_FETCH);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({IRWrite, PCWrite} !== 2'b11) begin
      errors++;
      $display("FAIL release_fetch: got IRWrite,PCWrite=%b expected 11", {IRWrite, PCWrite});
    end
    @(posedge clk); #1;
    // finish the instruction the release started as an ADD
    opcode = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    run_instr(4'b0010, 1'b0, 1'b0, 0, "rtype_and");
    run_instr(4'b0011, 1'b0, 1'b0, 0, "rtype_or");
    run_instr(4'b0001, 1'b0, 1'b0, 0, "rtype_sub");
    run_instr(4'b0100, 1'b0, 1'b0, 0, "addi");
  endtask

  task automatic test_mem();
    run_instr(4'b0101, 1'b0, 1'b0, 0, "lw");
    run_instr(4'b0110, 1'b0, 1'b0, 0, "sw");
  endtask

  task automatic test_branch();
    run_instr(4'b0111, 1'b1, 1'b0, 0, "beq_taken");
    run_instr(4'b0111, 1'b0, 1'b1, 0, "beq_not_taken");
    run_instr(4'b1000, 1'b0, 1'b1, 0, "bgt_taken");
    run_instr(4'b1000, 1'b1, 1'b1, 0, "bgt_equal");
    run_instr(4'b1000, 1'b0, 1'b0, 0, "bgt_less");
    run_instr(4'b1001, 1'b0, 1'b0, 0, "jump");
  endtask

  task automatic test_illegal();
    run_instr(4'b1111, 1'b0, 1'b0, 0, "illegal_1111");
    run_instr(4'b1010, 1'b1, 1'b1, 0, "illegal_1010");
  endtask

  task automatic test_reset_mid_memwr();
    run_instr(4'b0110, 1'b0, 1'b0, 3, "sw_prefix");
    opcode = 4'b0110;
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_before_reset: got MemWrite=%b expected 1", MemWrite);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({MemWrite, RegWrite, IRWrite, PCWrite, instr_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_memwr: got enables %b expected 00000",
               {MemWrite, RegWrite, IRWrite, PCWrite, instr_done});
    end
    checks++;
    if (state !== S_FETCH) begin
      errors++;
      $display("FAIL reset_mid_state: got %0d expected %0d", state, S_FETCH);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(4'b0101, 1'b0, 1'b0, 0, "lw_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic z, g;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      z = 1'($urandom);
      g = 1'($urandom);
      run_instr(op, z, g, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid_memwr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
